// File: rtl/hdd_sector_server_pkg.sv
// Shared types and sizes for the HDD sector server.
// Imported by the sector server top.
package hdd_sector_server_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int IMG_AW_DEF   = 25;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_PUT,
    WR_ADDR,
    WR_CAP,
    WR_REQ,
    DONE
  } state_t;

endpackage

// File: rtl/hdd_sector_server_req_edge.sv
// Rising-edge detector for the core read/write request levels.
// A read edge masks a write edge in the same cycle.
module hdd_req_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic rd,
  input  logic wr,
  output logic rd_rise,
  output logic wr_rise
);

  logic rd_q;
  logic wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
    end
  end

  assign rd_rise = rd & ~rd_q;
  assign wr_rise = wr & ~wr_q & ~rd_rise;

endmodule

// File: rtl/hdd_sector_server.sv
// Serves core sector reads/writes from a byte-wide image store.
// One byte moves per image request; the core buffer is 512 bytes.
module hdd_sector_server
  import hdd_sector_server_pkg::*;
#(
  parameter int IMG_AW       = IMG_AW_DEF,
  parameter int SECTOR_BYTES = hdd_sector_server_pkg::SECTOR_BYTES
) (
  input  logic              CLK_14M,
  input  logic              reset_n,
  input  logic [15:0]       HDD_SECTOR,
  input  logic              HDD_READ,
  input  logic              HDD_WRITE,
  output logic              HDD_MOUNTED,
  output logic              HDD_PROTECT,
  output logic [8:0]        HDD_RAM_ADDR,
  output logic [7:0]        HDD_RAM_DI,
  input  logic [7:0]        HDD_RAM_DO,
  output logic              HDD_RAM_WE,
  input  logic              mount_in,
  input  logic              protect_in,
  input  logic [15:0]       img_sectors,
  output logic [IMG_AW-1:0] img_addr,
  output logic              img_rd,
  output logic              img_wr,
  output logic [7:0]        img_wdata,
  input  logic [7:0]        img_rdata,
  input  logic              img_ack,
  output logic              busy,
  output logic              err
);

  localparam logic [8:0] LAST = 9'(SECTOR_BYTES - 1);

  state_t      state;
  logic [15:0] sector;
  logic [8:0]  cnt;
  logic        zero;
  logic        rd_rise;
  logic        wr_rise;
  logic        rd_bad;
  logic        wr_bad;

  function automatic logic [IMG_AW-1:0] addr_of(
    input logic [15:0] s,
    input logic [8:0]  c
  );
    return IMG_AW'({s, c});
  endfunction

  hdd_req_edge u_edge (
    .clk     (CLK_14M),
    .rst_n   (reset_n),
    .rd      (HDD_READ),
    .wr      (HDD_WRITE),
    .rd_rise (rd_rise),
    .wr_rise (wr_rise)
  );

  assign rd_bad = (HDD_SECTOR >= img_sectors) | ~mount_in;
  assign wr_bad = rd_bad | protect_in;

  always_ff @(posedge CLK_14M or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      sector       <= '0;
      cnt          <= '0;
      zero         <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      HDD_MOUNTED  <= 1'b0;
      HDD_PROTECT  <= 1'b0;
      HDD_RAM_ADDR <= '0;
      HDD_RAM_DI   <= '0;
      HDD_RAM_WE   <= 1'b0;
      img_addr     <= '0;
      img_rd       <= 1'b0;
      img_wr       <= 1'b0;
      img_wdata    <= '0;
    end else begin
      HDD_MOUNTED <= mount_in;
      HDD_PROTECT <= protect_in;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          cnt  <= '0;
          if (rd_rise) begin
            sector   <= HDD_SECTOR;
            busy     <= 1'b1;
            err      <= rd_bad;
            zero     <= rd_bad;
            img_rd   <= ~rd_bad;
            img_addr <= addr_of(HDD_SECTOR, 9'd0);
            state    <= RD_REQ;
          end else if (wr_rise) begin
            sector <= HDD_SECTOR;
            busy   <= 1'b1;
            err    <= wr_bad;
            if (wr_bad) begin
              state <= DONE;
            end else begin
              HDD_RAM_ADDR <= '0;
              state        <= WR_ADDR;
            end
          end
        end
        // Out-of-range or unmounted reads still fill the buffer, with zeros.
        RD_REQ: begin
          if (zero) begin
            HDD_RAM_ADDR <= cnt;
            HDD_RAM_DI   <= '0;
            HDD_RAM_WE   <= 1'b1;
            state        <= RD_PUT;
          end else if (img_ack) begin
            img_rd       <= 1'b0;
            HDD_RAM_ADDR <= cnt;
            HDD_RAM_DI   <= img_rdata;
            HDD_RAM_WE   <= 1'b1;
            state        <= RD_PUT;
          end
        end
        RD_PUT: begin
          HDD_RAM_WE <= 1'b0;
          cnt        <= cnt + 9'd1;
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            img_rd   <= ~zero;
            img_addr <= addr_of(sector, cnt + 9'd1);
            state    <= RD_REQ;
          end
        end
        WR_ADDR: state <= WR_CAP;
        WR_CAP: begin
          img_wdata <= HDD_RAM_DO;
          img_wr    <= 1'b1;
          img_addr  <= addr_of(sector, cnt);
          state     <= WR_REQ;
        end
        WR_REQ: begin
          if (img_ack) begin
            img_wr <= 1'b0;
            cnt    <= cnt + 9'd1;
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              HDD_RAM_ADDR <= cnt + 9'd1;
              state        <= WR_ADDR;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdd_sector_server.sv
// Directed bench for hdd_sector_server with a latency-varying image
// store model and a 512-byte core buffer model.
module tb_hdd_sector_server;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] HDD_SECTOR = '0;
  logic        HDD_READ = 1'b0;
  logic        HDD_WRITE = 1'b0;
  logic        HDD_MOUNTED;
  logic        HDD_PROTECT;
  logic [8:0]  HDD_RAM_ADDR;
  logic [7:0]  HDD_RAM_DI;
  logic [7:0]  HDD_RAM_DO = '0;
  logic        HDD_RAM_WE;
  logic        mount_in = 1'b0;
  logic        protect_in = 1'b0;
  logic [15:0] img_sectors = '0;
  logic [24:0] img_addr;
  logic        img_rd;
  logic        img_wr;
  logic [7:0]  img_wdata;
  logic [7:0]  img_rdata = '0;
  logic        img_ack = 1'b0;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  hdd_sector_server dut (
    .CLK_14M      (clk),
    .reset_n      (rst_n),
    .HDD_SECTOR   (HDD_SECTOR),
    .HDD_READ     (HDD_READ),
    .HDD_WRITE    (HDD_WRITE),
    .HDD_MOUNTED  (HDD_MOUNTED),
    .HDD_PROTECT  (HDD_PROTECT),
    .HDD_RAM_ADDR (HDD_RAM_ADDR),
    .HDD_RAM_DI   (HDD_RAM_DI),
    .HDD_RAM_DO   (HDD_RAM_DO),
    .HDD_RAM_WE   (HDD_RAM_WE),
    .mount_in     (mount_in),
    .protect_in   (protect_in),
    .img_sectors  (img_sectors),
    .img_addr     (img_addr),
    .img_rd       (img_rd),
    .img_wr       (img_wr),
    .img_wdata    (img_wdata),
    .img_rdata    (img_rdata),
    .img_ack      (img_ack),
    .busy         (busy),
    .err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0]  cbuf [512];
  logic [8:0]  we_a [512];
  logic [7:0]  we_d [512];
  logic [24:0] rd_a [512];
  logic [24:0] wr_a [512];
  logic [7:0]  wr_d [512];
  int we_n, rd_n, wr_n, rd_cyc, coll, busy_cyc;
  int wait_c;

  // Core-side buffer: registered read port, writes observed mid-cycle.
  always @(posedge clk) HDD_RAM_DO <= cbuf[HDD_RAM_ADDR];

  always @(negedge clk) begin
    if (HDD_RAM_WE) begin
      if (we_n < 512) begin
        we_a[we_n] = HDD_RAM_ADDR;
        we_d[we_n] = HDD_RAM_DI;
      end
      cbuf[HDD_RAM_ADDR] = HDD_RAM_DI;
      we_n++;
    end
    if (img_rd) rd_cyc++;
    if (int'(img_rd) + int'(img_wr) + int'(HDD_RAM_WE) > 1) coll++;
    if (busy) busy_cyc++;
  end

  // Image store: pattern byte = addr[7:0], ack after 0..2 idle cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_ack <= 1'b0;
      wait_c = 0;
    end else begin
      img_ack <= 1'b0;
      if ((img_rd || img_wr) && !img_ack) begin
        if (wait_c == 0) begin
          img_ack   <= 1'b1;
          img_rdata <= img_addr[7:0];
          wait_c = int'(img_addr % 3);
          if (img_rd) begin
            if (rd_n < 512) rd_a[rd_n] = img_addr;
            rd_n++;
          end else begin
            if (wr_n < 512) begin
              wr_a[wr_n] = img_addr;
              wr_d[wr_n] = img_wdata;
            end
            wr_n++;
          end
        end else begin
          wait_c = wait_c - 1;
        end
      end
    end
  end

  task automatic clr();
    we_n = 0; rd_n = 0; wr_n = 0;
    rd_cyc = 0; coll = 0; busy_cyc = 0;
  endtask

  task automatic req(input logic r, input logic w, input logic [15:0] s);
    @(negedge clk);
    HDD_SECTOR = s;
    HDD_READ   = r;
    HDD_WRITE  = w;
    @(negedge clk);
    HDD_READ  = 1'b0;
    HDD_WRITE = 1'b0;
  endtask

  task automatic run_until_idle(input string tag);
    int t;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_busy_on"}, busy, 1);
    t = 0;
    while (busy && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  task automatic chk_read(input string tag, input int base, input bit z);
    int ba, bd, br;
    ba = 0; bd = 0; br = 0;
    for (int i = 0; i < 512; i++) begin
      if (we_a[i] !== 9'(i)) ba++;
      if (we_d[i] !== (z ? 8'h00 : 8'(base + i))) bd++;
      if (!z && rd_a[i] !== 25'(base + i)) br++;
    end
    chk({tag, "_we_n"}, we_n, 512);
    chk({tag, "_we_addr_bad"}, ba, 0);
    chk({tag, "_we_data_bad"}, bd, 0);
    chk({tag, "_rd_n"}, rd_n, z ? 0 : 512);
    chk({tag, "_rd_addr_bad"}, br, 0);
    chk({tag, "_wr_n"}, wr_n, 0);
    chk({tag, "_collide"}, coll, 0);
  endtask

  initial begin
    int t, ba, bd;
    for (int i = 0; i < 512; i++) cbuf[i] = 8'h00;
    clr();
    mount_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", {busy, err, HDD_RAM_WE, img_rd, img_wr,
        HDD_RAM_ADDR, HDD_RAM_DI, img_wdata, HDD_MOUNTED, HDD_PROTECT}, 0);
    chk("rst_img_addr", img_addr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    img_sectors = 16'd16;
    @(negedge clk);
    chk("mounted_copy", HDD_MOUNTED, 1);

    // Read sector 3
    clr();
    req(1'b1, 1'b0, 16'd3);
    run_until_idle("rd3");
    chk_read("rd3", 1536, 1'b0);
    chk("rd3_err", err, 0);

    // Write sector 5 from buffer i^A5
    for (int i = 0; i < 512; i++) cbuf[i] = 8'(i) ^ 8'hA5;
    clr();
    req(1'b0, 1'b1, 16'd5);
    run_until_idle("wr5");
    ba = 0; bd = 0;
    for (int i = 0; i < 512; i++) begin
      if (wr_a[i] !== 25'(2560 + i)) ba++;
      if (wr_d[i] !== (8'(i) ^ 8'hA5)) bd++;
    end
    chk("wr5_wr_n", wr_n, 512);
    chk("wr5_addr_bad", ba, 0);
    chk("wr5_data_bad", bd, 0);
    chk("wr5_we_n", we_n, 0);
    chk("wr5_rd_n", rd_n, 0);
    chk("wr5_collide", coll, 0);
    chk("wr5_err", err, 0);

    // Protected write
    protect_in = 1'b1;
    clr();
    req(1'b0, 1'b1, 16'd5);
    run_until_idle("wrp");
    chk("wrp_wr_n", wr_n, 0);
    chk("wrp_err", err, 1);
    chk("wrp_busy_cyc", busy_cyc, 2);
    chk("wrp_protect", HDD_PROTECT, 1);
    protect_in = 1'b0;

    // Out-of-range read: zero fill
    img_sectors = 16'h0100;
    for (int i = 0; i < 512; i++) cbuf[i] = 8'hFF;
    clr();
    req(1'b1, 1'b0, 16'h0100);
    run_until_idle("rdz");
    chk_read("rdz", 0, 1'b1);
    chk("rdz_rd_cyc", rd_cyc, 0);
    chk("rdz_err", err, 1);
    bd = 0;
    for (int i = 0; i < 512; i++) if (cbuf[i] !== 8'h00) bd++;
    chk("rdz_buf_nonzero", bd, 0);

    // Simultaneous edges; a later read edge mid-transfer is ignored
    img_sectors = 16'd16;
    clr();
    req(1'b1, 1'b1, 16'd2);
    t = 0;
    while (we_n < 100 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("both_reach100", we_n >= 100, 1);
    req(1'b1, 1'b0, 16'd7);
    run_until_idle("both");
    repeat (10) @(negedge clk);
    chk("both_idle", busy, 0);
    chk_read("both", 1024, 1'b0);
    chk("both_err_clr", err, 0);

    // Asynchronous reset mid-read, level held high across release
    clr();
    req(1'b1, 1'b0, 16'd1);
    t = 0;
    while (we_n < 200 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach200", we_n >= 200, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {busy, err, HDD_RAM_WE, img_rd, img_wr,
        HDD_RAM_ADDR, HDD_RAM_DI, img_wdata, HDD_MOUNTED, HDD_PROTECT}, 0);
    chk("mid_rst_img_addr", img_addr, 0);
    HDD_SECTOR = 16'd4;
    HDD_READ   = 1'b1;
    repeat (2) @(negedge clk);
    clr();
    rst_n = 1'b1;
    run_until_idle("rst_rd4");
    HDD_READ = 1'b0;
    chk_read("rst_rd4", 2048, 1'b0);
    chk("rst_rd4_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
